srt_otf_converter: RTL
======================

Name: srt_otf_converter

Overview:
- Consumer of the radix-4 SRT quotient-digit stream.
- Accepts one signed digit per iteration in 3-bit RBSD encoding: 110=-2, 101=-1, 000=0, 001=+1, 010=+2.
- Converts the digits to a conventional binary quotient using on-the-fly conversion (Q/QM register pair), so no carry-propagate adder is needed at the end.
- Applies the final negative-remainder correction and hands the quotient to the divider's result stage over a valid/ready handshake.

Parameters:
- NQ, 16, quotient width in bits; must be even and >= 4.
- NDIG, NQ/2, number of radix-4 digits per division (derived; do not override).
- CW, $clog2(NDIG+1), digit counter width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new conversion.
- digit_valid  in  1  q_jplus1 present on this cycle.
- digit_ready  out  1  converter accepts a digit this cycle.
- q_jplus1  in  3  quotient digit, RBSD code.
- rem_valid  in  1  final remainder sign present.
- rem_neg  in  1  final partial remainder is negative.
- q_valid  out  1  quotient output valid.
- q_ready  in  1  downstream accepts quotient.
- quotient  out  NQ  converted, corrected quotient.
- busy  out  1  conversion in progress.
- digit_err  out  1  sticky illegal-digit flag (see Optional Feature).

Behaviour:
- Reset is synchronous, active-low: clk rising edge with rst_n=0.
  - Outputs: digit_ready=0, q_valid=0, busy=0, quotient=0, digit_err=0.
  - Internal: state=IDLE, Q=0, QM=all ones, cnt=0.
  - A reset mid-operation aborts the conversion; no quotient is produced.
- FSM states: IDLE, ACCUM, WAIT_REM, DONE.
- IDLE:
  - On start: Q<=0, QM<=all ones (-1 mod 2^NQ), cnt<=0, digit_err<=0, go to ACCUM.
- ACCUM:
  - digit_ready=1, busy=1.
  - A digit transfers when digit_valid && digit_ready.
  - Per accepted digit q, with 2-bit left shift and the top 2 bits discarded:
    - Q update: q>=0: Q<=(Q<<2)|q. q<0: Q<=(QM<<2)|(4+q).
    - QM update: q>0: QM<=(Q<<2)|(q-1). q<=0: QM<=(QM<<2)|(3+q).
    - cnt<=cnt+1.
  - When the NDIG-th digit is accepted, go to WAIT_REM; digit_ready drops the next cycle.
- WAIT_REM:
  - busy=1, digit_ready=0.
  - On rem_valid: quotient<=rem_neg ? QM : Q, q_valid<=1, go to DONE.
  - Latency: quotient is valid the cycle after rem_valid.
- DONE:
  - quotient and q_valid are held stable until q_ready is sampled high; then q_valid<=0 and go to IDLE.
  - busy=0 in DONE.
- start in ACCUM or WAIT_REM: aborts, reinitialises Q/QM/cnt, stays in or returns to ACCUM.
- start in DONE: ignored until the handshake completes.
  - Exception: start and q_ready in the same cycle completes the transfer and enters ACCUM directly.
- Ignored inputs:
  - digit_valid outside ACCUM.
  - rem_valid outside WAIT_REM.
  - rem_valid arriving in the same cycle as the final digit; the source must present it at least one cycle later.
- Illegal codes 011, 100, 111 are decoded as digit 0 (counter still advances).
- All arithmetic is modulo 2^NQ; a first digit of -1 or -2 yields two's-complement Q, which is correct.

Optional Feature:
- Macro: SRT_DIGIT_CHECK_EN.
- Defined:
  - An accepted illegal code sets digit_err.
  - digit_err stays sticky until the next start or reset.
  - digit_err is also held with the quotient while in DONE.
- Undefined:
  - digit_err is tied to 0.
  - Illegal codes are still decoded as 0; no detection logic is synthesised.

Decomposition:
- Shared package srt_pkg:
  - RBSD codes as localparams: RBSD_M2=3'b110, RBSD_M1=3'b101, RBSD_ZERO=3'b000, RBSD_P1=3'b001, RBSD_P2=3'b010.
  - FSM state encoding.
  - A digit-legality function.
- One natural sub-module: srt_otf_step.
  - Combinational.
  - Given Q, QM and a digit, produces next Q and next QM.
  - Reused by any future multi-digit-per-cycle variant.

Test Plan:
- NQ=16, start, digits +2 then seven 0, rem_neg=0 -> quotient=16'h8000, q_valid asserted one cycle after rem_valid.
- Eight +1 digits, rem_neg=0 -> 16'h5555; same digits with rem_neg=1 -> 16'h5554.
- Digits +1 then seven -1, rem_neg=0 -> 16'h2AAB. Separately, digits -1 then seven 0 -> 16'hC000 (mod-2^16 wrap check).
- Backpressure: q_ready held 0 for 5 cycles -> quotient and q_valid stable throughout. Random digit_valid gaps -> same result as the gap-free run.
- Reset and restart:
  - rst_n=0 after 3 digits -> all outputs 0, FSM in IDLE.
  - start after 4 digits -> new 8-digit run gives a correct result, with no contamination from the aborted digits.
- With SRT_DIGIT_CHECK_EN: a code 011 in position 3 of eight +1 digits -> digit_err=1 and quotient=16'h5455. Without the macro: same quotient, digit_err=0.

Source files
------------

// File: rtl/srt_pkg.sv
// srt_pkg: shared RBSD digit codes, converter FSM states and a digit-legality helper.
package srt_pkg;
  localparam logic [2:0] RBSD_M2   = 3'b110;
  localparam logic [2:0] RBSD_M1   = 3'b101;
  localparam logic [2:0] RBSD_ZERO = 3'b000;
  localparam logic [2:0] RBSD_P1   = 3'b001;
  localparam logic [2:0] RBSD_P2   = 3'b010;
  typedef enum logic [1:0] {IDLE, ACCUM, WAIT_REM, DONE} state_t;
  function automatic logic rbsd_legal(input logic [2:0] code);
    return code == RBSD_M2 || code == RBSD_M1 || code == RBSD_ZERO ||
           code == RBSD_P1 || code == RBSD_P2;
  endfunction
endpackage

// File: rtl/srt_otf_step.sv
// srt_otf_step: one radix-4 on-the-fly conversion step; appends a signed digit to the Q/QM pair.
module srt_otf_step
  import srt_pkg::*;
#(
  parameter int NQ = 16
) (
  input  logic [NQ-1:0] q,
  input  logic [NQ-1:0] qm,
  input  logic [2:0]    code,
  output logic [NQ-1:0] q_nx,
  output logic [NQ-1:0] qm_nx
);
  logic signed [2:0] v;
  logic signed [2:0] vm;
  logic [NQ-1:0] q_src;
  logic [NQ-1:0] qm_src;
  // Negative digits borrow from QM, positive digits let QM track Q; low bits are digit mod 4.
  always_comb begin
    v = code == RBSD_P2 ? 3'sb010 :
        code == RBSD_P1 ? 3'sb001 :
        code == RBSD_M1 ? 3'sb111 :
        code == RBSD_M2 ? 3'sb110 : 3'sb000;
    vm = v - 3'sb001;
    q_src = v[2] ? qm : q;
    qm_src = (!v[2] && v != 3'sb000) ? q : qm;
    q_nx = {q_src[NQ-3:0], v[1:0]};
    qm_nx = {qm_src[NQ-3:0], vm[1:0]};
  end
endmodule

// File: rtl/srt_otf_converter.sv
// srt_otf_converter: radix-4 SRT digit stream to binary quotient with sign correction; optional SRT_DIGIT_CHECK_EN flags illegal digit codes.
module srt_otf_converter
  import srt_pkg::*;
#(
  parameter  int NQ   = 16,
  localparam int NDIG = NQ / 2,
  localparam int CW   = $clog2(NDIG + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          digit_valid,
  output logic          digit_ready,
  input  logic [2:0]    q_jplus1,
  input  logic          rem_valid,
  input  logic          rem_neg,
  output logic          q_valid,
  input  logic          q_ready,
  output logic [NQ-1:0] quotient,
  output logic          busy,
  output logic          digit_err
);
  state_t state, state_nx;
  logic [NQ-1:0] q_r, qm_r, q_nx, qm_nx;
  logic [CW-1:0] cnt;
  logic acc, init, last;

  srt_otf_step #(.NQ(NQ)) u_step (
    .q(q_r), .qm(qm_r), .code(q_jplus1), .q_nx(q_nx), .qm_nx(qm_nx)
  );

  assign acc  = state == ACCUM && digit_valid;
  assign init = start && (state != DONE || q_ready);
  assign last = acc && cnt == CW'(NDIG - 1);

  // Next state and handshake outputs; start (when honoured) always restarts accumulation.
  always_comb begin
    state_nx = init ? ACCUM :
               state == ACCUM    ? (last ? WAIT_REM : ACCUM) :
               state == WAIT_REM ? (rem_valid ? DONE : WAIT_REM) :
               state == DONE     ? (q_ready ? IDLE : DONE) : IDLE;
    digit_ready = state == ACCUM;
    busy = state == ACCUM || state == WAIT_REM;
    q_valid = state == DONE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  // Q/QM accumulation, digit count and the corrected quotient capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r <= '0;
      qm_r <= '1;
      cnt <= '0;
      quotient <= '0;
    end else if (init) begin
      q_r <= '0;
      qm_r <= '1;
      cnt <= '0;
    end else begin
      if (acc) begin
        q_r <= q_nx;
        qm_r <= qm_nx;
        cnt <= cnt + CW'(1);
      end
      if (state == WAIT_REM && rem_valid) quotient <= rem_neg ? qm_r : q_r;
    end
  end

`ifdef SRT_DIGIT_CHECK_EN
  logic err;
  assign digit_err = err;
  // Sticky illegal-code flag, cleared only by reset or an honoured start.
  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else if (init) err <= 1'b0;
    else if (acc && !rbsd_legal(q_jplus1)) err <= 1'b1;
  end
`else
  assign digit_err = 1'b0;
`endif
endmodule
